// File: rtl/keccak_pkg.sv
// Shared Keccak constants: lane geometry, rho rotation offsets and the
// FSM state encoding used by the rho / inverse-rho lane rotators.
package keccak_pkg;

    localparam int unsigned LANE_W    = 64;
    localparam int unsigned NUM_LANES = 25;
    localparam int unsigned STATE_W   = LANE_W * NUM_LANES;
    localparam int unsigned ROT_W     = 6;
    localparam int unsigned LC_W      = 5;

    // Per-lane rho offsets, lane index i = x + 5*y.
    localparam logic [ROT_W-1:0] RHO_OFFSETS [NUM_LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        FSM_IDLE = ST_IDLE,
        FSM_RUN  = ST_RUN,
        FSM_DONE = ST_DONE
    } rho_fsm_e;

endpackage

// File: rtl/rotate_right_lane.sv
// Combinational 64-bit lane rotate-right by a 6-bit amount.
// Ports:
//   lane     - input lane value
//   amount   - rotate distance, 0..63
//   result_c - lane rotated right by amount (identity when amount == 0)
module rotate_right_lane
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    input  logic [ROT_W-1:0]  amount,
    output logic [LANE_W-1:0] result_c
);

    // Left-shift distance (64 - amount) mod 64, computed in 6-bit arithmetic.
    logic [ROT_W-1:0] back;

    assign back = ROT_W'(0) - amount;

    // Explicit bypass keeps amount == 0 an exact identity.
    assign result_c = (amount == '0) ? lane : ((lane >> amount) | (lane << back));

endmodule

// File: rtl/keccak_inv_rho.sv
// Sequential inverse Keccak rho: rotates each 64-bit lane of a captured
// 1600-bit state right by its rho offset, LANES_PER_CYCLE lanes per cycle,
// and presents the result over a valid/ready handshake.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake (ready only in IDLE)
//   in_state            - input state, lane i at bits [64*i +: 64]
//   out_valid/out_ready - output handshake (valid only in DONE)
//   out_state           - work register, same lane packing
//   busy                - high while in RUN or DONE
module keccak_inv_rho
    import keccak_pkg::*;
#(
    parameter int unsigned LANES_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int unsigned LAST_LC = NUM_LANES - LANES_PER_CYCLE;

    if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 5 || LANES_PER_CYCLE == 25)) begin : g_bad_lpc
        $error("keccak_inv_rho: LANES_PER_CYCLE must be 1, 5 or 25");
    end

    rho_fsm_e            state_q, state_d;
    logic [LC_W-1:0]     lc_q, lc_d;
    logic [STATE_W-1:0]  work_q, work_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [LC_W-1:0]     lane_idx [LANES_PER_CYCLE];
    logic [LANE_W-1:0]   lane_in  [LANES_PER_CYCLE];
    logic [LANE_W-1:0]   lane_out [LANES_PER_CYCLE];

    // One rotator per lane slot; each picks its lane and offset by lc.
    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
        assign lane_idx[j] = lc_q + LC_W'(j);
        assign lane_in[j]  = work_q[LANE_W*lane_idx[j] +: LANE_W];

        rotate_right_lane u_rot (
            .lane     (lane_in[j]),
            .amount   (RHO_OFFSETS[lane_idx[j]]),
            .result_c (lane_out[j])
        );
    end

    // Next-state, lane counter and work-register update.
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        work_d  = work_q;
        case (state_q)
            FSM_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_state;
                    lc_d    = '0;
                    state_d = FSM_RUN;
                end
            end
            FSM_RUN: begin
                for (int j = 0; j < int'(LANES_PER_CYCLE); j++) begin
                    work_d[LANE_W*lane_idx[j] +: LANE_W] = lane_out[j];
                end
                // lc holds on the final group so it never passes lane 24.
                if (lc_q == LC_W'(LAST_LC)) begin
                    state_d = FSM_DONE;
                end else begin
                    lc_d = lc_q + LC_W'(LANES_PER_CYCLE);
                end
            end
            FSM_DONE: begin
                if (out_ready) begin
                    state_d = FSM_IDLE;
                end
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FSM_IDLE;
            lc_q        <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lc_q        <= lc_d;
            work_q      <= work_d;
            in_ready_q  <= (state_d == FSM_IDLE);
            out_valid_q <= (state_d == FSM_DONE);
            busy_q      <= (state_d != FSM_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule
